alu_8_issue: RTL and testbench

//  Issue/writeback stage wrapped around alu_8. Holds the 8x8 Z80-style register file and flag register F.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_regfile_8.sv | 42 ++++
 rtl/alu_8_issue.sv | 140 ++++++++++++++
 tb/tb_alu_8_issue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_8 issue/writeback stage.
package alu_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_COUNT = 8;
    localparam logic [2:0] REG_HL_IDX = 3'd6;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_H  = 4;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd6,
        OP_SRL   = 5'd7,
        OP_SLA   = 5'd8,
        OP_SRA   = 5'd9,
        OP_RL    = 5'd10,
        OP_RR    = 5'd11,
        OP_SET   = 5'd14,
        OP_RESET = 5'd15,
        OP_TEST  = 5'd16
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} issue_state_e;

    // Opcodes whose result is written back to the destination register.
    function automatic logic op_writes(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA,
            OP_SRA, OP_RL, OP_RR, OP_SET, OP_RESET: op_writes = 1'b1;
            default:                                 op_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile_8.sv
// 8x8 Z80-style register file: two operand read ports, a debug read port, one write port.
// Index 6 stands for (HL): it always reads 8'h00 and ignores writes.
module alu_regfile_8
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [2:0]        rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] r_mem [REG_COUNT];

    function automatic logic [DATA_W-1:0] rd(input logic [2:0] addr,
                                             input logic [DATA_W-1:0] mem [REG_COUNT]);
        return (addr == REG_HL_IDX) ? '0 : mem[addr];
    endfunction

    always_comb begin
        rd_a_data = rd(rd_a_addr, r_mem);
        rd_b_data = rd(rd_b_addr, r_mem);
        dbg_data  = rd(dbg_addr, r_mem);
    end

    // NOTE: the register file is architecturally cleared by reset, so every entry is
    // reset here; storage without a required reset value would be left out of this branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
        end else if (wr_en && wr_addr != REG_HL_IDX) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/alu_8_issue.sv
// Issue/writeback stage around the combinational alu_8: latches a request, reads operands,
// drives the ALU, captures its output, then writes back and updates the F register.
module alu_8_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_opcode,
    input  logic [2:0]        req_dst,
    input  logic [2:0]        req_src,
    input  logic [DATA_W-1:0] req_imm,
    input  logic              req_use_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] flags,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    issue_state_e      r_state;
    logic [4:0]        r_opcode;
    logic [2:0]        r_dst;
    logic [2:0]        r_src;
    logic [DATA_W-1:0] r_imm;
    logic              r_use_imm;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [4:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_flags;
    logic              r_done;
    logic              r_illegal;
    logic              r_req_ready;

    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic              w_writes;
    logic              w_flag_upd;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_new_flags;

    alu_regfile_8 u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (r_dst),
        .rd_a_data (w_rd_a),
        .rd_b_addr (r_src),
        .rd_b_data (w_rd_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (w_wr_en),
        .wr_addr   (r_dst),
        .wr_data   (r_result)
    );

    // NOTE: every signal gets a default before the conditional logic so no latch is inferred.
    always_comb begin
        w_writes    = op_writes(r_opcode);
        w_flag_upd  = w_writes || (r_opcode == OP_TEST);
        w_wr_en     = (r_state == WB) && w_writes;
        w_new_flags = '0;
        w_new_flags[FLAG_S]  = r_result[DATA_W-1];
        w_new_flags[FLAG_Z]  = (r_result == '0);
        w_new_flags[FLAG_PV] = ~^r_result;
        w_new_flags[FLAG_N]  = (r_opcode == OP_SUB);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_opcode     <= '0;
            r_dst        <= '0;
            r_src        <= '0;
            r_imm        <= '0;
            r_use_imm    <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_result     <= '0;
            r_flags      <= '0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_req_ready  <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_opcode    <= req_opcode;
                        r_dst       <= req_dst;
                        r_src       <= req_src;
                        r_imm       <= req_imm;
                        r_use_imm   <= req_use_imm;
                        r_req_ready <= 1'b0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_alu_a      <= w_rd_a;
                    r_alu_b      <= r_use_imm ? r_imm : w_rd_b;
                    r_alu_opcode <= r_opcode;
                    r_state      <= EXEC;
                end
                EXEC: begin
                    r_result  <= alu_out;
                    r_done    <= 1'b1;
                    r_illegal <= ~w_flag_upd;
                    r_state   <= WB;
                end
                WB: begin
                    // Register write happens through the regfile port on this same edge.
                    if (w_flag_upd) r_flags <= w_new_flags;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign done       = r_done;
    assign result     = r_result;
    assign flags      = r_flags;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_8_issue.sv
// Directed bench for alu_8_issue; a small combinational alu_8 stand-in closes the loop.
module tb_alu_8_issue;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_opcode = '0;
    logic [2:0] req_dst = '0;
    logic [2:0] req_src = '0;
    logic [7:0] req_imm = '0;
    logic       req_use_imm = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [4:0] alu_opcode;
    logic       done, illegal;
    logic [7:0] result, flags;
    logic [2:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_8_issue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_dst(req_dst), .req_src(req_src), .req_imm(req_imm), .req_use_imm(req_use_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .done(done), .result(result), .flags(flags), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural alu_8 stand-in.
    always_comb begin
        alu_out = 8'h00;
        case (alu_opcode)
            5'd0:  alu_out = alu_a + alu_b;
            5'd1:  alu_out = alu_a - alu_b;
            5'd2:  alu_out = alu_a & alu_b;
            5'd3:  alu_out = alu_a | alu_b;
            5'd4:  alu_out = alu_a ^ alu_b;
            5'd6:  alu_out = alu_a << 1;
            5'd7:  alu_out = alu_a >> 1;
            5'd8:  alu_out = alu_a << 1;
            5'd9:  alu_out = {alu_a[7], alu_a[7:1]};
            5'd10: alu_out = {alu_a[6:0], alu_a[7]};
            5'd11: alu_out = {alu_a[0], alu_a[7:1]};
            5'd14: alu_out = alu_a | (8'd1 << alu_b[2:0]);
            5'd15: alu_out = alu_a & ~(8'd1 << alu_b[2:0]);
            5'd16: alu_out = alu_a & alu_b;
            default: alu_out = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_read(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    // Issues one request, waits (bounded) for done, then steps into the cycle after WB.
    task automatic issue(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic use_imm,
                         output int lat, output logic [7:0] res, output logic ill);
        int n;
        n = 0;
        req_opcode = op; req_dst = dst; req_src = src; req_imm = imm; req_use_imm = use_imm;
        req_valid = 1'b1;
        while (!req_ready && n < 8) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        res = result;
        ill = illegal;
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int lat;
        logic [7:0] res, d;
        logic ill;
        int acc, dones;

        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] res, d;
        logic ill;
        int acc, dones;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", req_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_flags", flags, 8'h00);
        check("rst_alu_a", alu_a, 8'h00);
        for (int i = 0; i < 8; i++) begin
            dbg_read(i[2:0], d);
            check($sformatf("rst_reg%0d", i), d, 8'h00);
        end

        // OR r7, 0x3C
        issue(5'd3, 3'd7, 3'd0, 8'h3C, 1'b1, lat, res, ill);
        check("or_latency", lat, 3);
        check("or_result", res, 8'h3C);
        check("or_illegal", ill, 1'b0);
        check("or_flags", flags, 8'h04);
        dbg_read(3'd7, d);
        check("or_reg7", d, 8'h3C);

        // ADD r7, 0x07
        issue(5'd0, 3'd7, 3'd0, 8'h07, 1'b1, lat, res, ill);
        check("add_result", res, 8'h43);
        check("add_flags", flags, 8'h00);
        check("alu_hold_a", alu_a, 8'h3C);

        // SUB r7, r7: operand read before writeback
        issue(5'd1, 3'd7, 3'd7, 8'hAA, 1'b0, lat, res, ill);
        check("sub_result", res, 8'h00);
        check("sub_flags", flags, 8'h46);
        dbg_read(3'd7, d);
        check("sub_reg7", d, 8'h00);

        // OR (HL), 0xFF: no storage, flags still update
        issue(5'd3, 3'd6, 3'd0, 8'hFF, 1'b1, lat, res, ill);
        check("hl_result", res, 8'hFF);
        check("hl_flags", flags, 8'h84);
        dbg_read(3'd6, d);
        check("hl_reg6", d, 8'h00);

        // Load r3, then TEST and an unsupported opcode against it
        issue(5'd3, 3'd3, 3'd0, 8'hA5, 1'b1, lat, res, ill);
        check("ld3_flags", flags, 8'h84);
        issue(5'd16, 3'd3, 3'd0, 8'h0F, 1'b1, lat, res, ill);
        check("test_result", res, 8'h05);
        check("test_illegal", ill, 1'b0);
        check("test_flags", flags, 8'h04);
        dbg_read(3'd3, d);
        check("test_reg3", d, 8'hA5);
        issue(5'd5, 3'd3, 3'd0, 8'h11, 1'b1, lat, res, ill);
        check("op5_latency", lat, 3);
        check("op5_illegal", ill, 1'b1);
        check("op5_flags", flags, 8'h04);
        dbg_read(3'd3, d);
        check("op5_reg3", d, 8'hA5);

        // req_valid held high: accepts only in IDLE, one every 4 cycles
        acc = 0;
        dones = 0;
        req_opcode = 5'd0; req_dst = 3'd2; req_imm = 8'h01; req_use_imm = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("held_ready_k%0d", k), req_ready, (k % 4 == 0));
            if (req_ready) acc++;
            if (done) dones++;
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            tick();
        end
        check("held_accepts", acc, 2);
        check("held_dones", dones, 2);
        dbg_read(3'd2, d);
        check("held_reg2", d, 8'h02);

        // Reset during EXEC drops the in-flight op
        req_opcode = 5'd0; req_dst = 3'd1; req_imm = 8'h10; req_use_imm = 1'b1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", req_ready, 1'b1);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) dones++;
            tick();
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_flags", flags, 8'h00);
        dbg_read(3'd1, d);
        check("mid_rst_reg1", d, 8'h00);
        dbg_read(3'd3, d);
        check("mid_rst_reg3", d, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
